rob_commit_ctrl: RTL and testbench

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

---
 rtl/rob_commit_ctrl_pkg.sv | 28 ++
 rtl/rob_commit_ctrl_if.sv | 59 +++++
 rtl/rob_commit_ctrl.sv | 119 +++++++++++
 tb/tb_rob_commit_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared CPU defines for the reorder-buffer commit controller.
//
// Contents:
//   ROB_DEPTH   - number of reorder entries. It is 16 because the
//                 register-file rename tags are 4 bits wide.
//   TAG_W       - tag width. One tag names one ROB entry.
//   CNT_W       - occupancy counter width. It holds 0..ROB_DEPTH.
//   tag_t       - ROB tag type.
//   rob_entry_t - per-entry record {busy, done, has_rd, rd, val}.
package rob_commit_ctrl_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int TAG_W     = 4;
   localparam int CNT_W     = 5;
   localparam int RD_W      = 5;
   localparam int VAL_W     = 32;

   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic             busy;
      logic             done;
      logic             has_rd;
      logic [RD_W-1:0]  rd;
      logic [VAL_W-1:0] val;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Bus bundle between the dispatch/execute/register-file side and the ROB.
//
// Signal groups:
//   rdy                                    - global enable
//   alloc_valid/has_rd/rd, alloc_ready/tag - dispatch allocation
//   wb_valid/tag/val                       - execution-unit writeback
//   rf_in_flag/a/rob                       - rename write to the register file
//   rf_out_flag/a/val/rob                  - commit write to the register file
//   flush, rf_clear                        - mispredict squash
//   q1/q2 tag, ready, val                  - operand forwarding query
//
// Modports:
//   master - the pipeline side, which drives the requests
//   slave  - the ROB itself
interface rob_commit_ctrl_if;
   import rob_commit_ctrl_pkg::*;

   logic              rdy;
   logic              alloc_valid;
   logic              alloc_has_rd;
   logic [RD_W-1:0]   alloc_rd;
   logic              alloc_ready;
   tag_t              alloc_tag;
   logic              wb_valid;
   tag_t              wb_tag;
   logic [VAL_W-1:0]  wb_val;
   logic              rf_in_flag;
   logic [RD_W-1:0]   rf_in_a;
   tag_t              rf_in_rob;
   logic              rf_out_flag;
   logic [RD_W-1:0]   rf_out_a;
   logic [VAL_W-1:0]  rf_out_val;
   tag_t              rf_out_rob;
   logic              flush;
   logic              rf_clear;
   tag_t              q1_tag;
   tag_t              q2_tag;
   logic              q1_ready;
   logic              q2_ready;
   logic [VAL_W-1:0]  q1_val;
   logic [VAL_W-1:0]  q2_val;

   modport master (
      output rdy, alloc_valid, alloc_has_rd, alloc_rd, wb_valid, wb_tag, wb_val,
             flush, q1_tag, q2_tag,
      input  alloc_ready, alloc_tag, rf_in_flag, rf_in_a, rf_in_rob,
             rf_out_flag, rf_out_a, rf_out_val, rf_out_rob, rf_clear,
             q1_ready, q2_ready, q1_val, q2_val
   );

   modport slave (
      input  rdy, alloc_valid, alloc_has_rd, alloc_rd, wb_valid, wb_tag, wb_val,
             flush, q1_tag, q2_tag,
      output alloc_ready, alloc_tag, rf_in_flag, rf_in_a, rf_in_rob,
             rf_out_flag, rf_out_a, rf_out_val, rf_out_rob, rf_clear,
             q1_ready, q2_ready, q1_val, q2_val
   );

endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer commit controller.
//
// The module keeps a 16-entry circular buffer. Dispatch allocates entries at
// the tail, execution units write results back by tag, and completed entries
// retire from the head, at most one per cycle. A flush squashes every entry
// at once.
//
// Ports:
//   clk - system clock. All state updates on the rising edge.
//   rst - asynchronous reset, active low.
//   bus - rob_commit_ctrl_if.slave. It carries the dispatch, writeback,
//         register-file, flush and forwarding signals.
//
// Configuration:
//   ROB_BYPASS_EN - when defined, the q1/q2 forwarding ports return the
//                   ready flag and stored value of the queried entry. When
//                   not defined, those outputs are tied to 0.
module rob_commit_ctrl #(
   parameter int ROB_DEPTH = rob_commit_ctrl_pkg::ROB_DEPTH
) (
   input logic               clk,
   input logic               rst,
   rob_commit_ctrl_if.slave  bus
);
   import rob_commit_ctrl_pkg::*;

   rob_entry_t        entries [ROB_DEPTH];
   tag_t              head;
   tag_t              tail;
   logic [CNT_W-1:0]  count;
   logic              out_en;
   logic              full;
   logic              accept;
   logic              commit;
   rob_entry_t        head_entry;

   // Outputs are gated by rst as well as rdy.
   // This keeps every strobe at 0 while reset is held, even though the
   // inputs may still be toggling.
   assign out_en     = bus.rdy && rst;
   assign full       = (count == CNT_W'(ROB_DEPTH));
   assign head_entry = entries[head];

   // Flush takes priority: it blocks both accept and commit in its cycle.
   // Commit needs the done bit to be already registered, so an entry cannot
   // retire in the same cycle its writeback arrives.
   assign accept = bus.alloc_valid && bus.alloc_ready;
   assign commit = out_en && !bus.flush && head_entry.busy && head_entry.done;

   assign bus.alloc_ready = out_en && !full && !bus.flush;
   assign bus.alloc_tag   = tail;
   assign bus.rf_clear    = out_en && bus.flush;

   // Register 0 is hardwired, so neither rename nor commit writes to it.
   assign bus.rf_in_flag  = accept && bus.alloc_has_rd && (bus.alloc_rd != '0);
   assign bus.rf_in_a     = bus.rf_in_flag ? bus.alloc_rd : '0;
   assign bus.rf_in_rob   = bus.rf_in_flag ? tail : '0;

   assign bus.rf_out_flag = commit && head_entry.has_rd && (head_entry.rd != '0);
   assign bus.rf_out_a    = bus.rf_out_flag ? head_entry.rd : '0;
   assign bus.rf_out_val  = bus.rf_out_flag ? head_entry.val : '0;
   assign bus.rf_out_rob  = bus.rf_out_flag ? head : '0;

`ifdef ROB_BYPASS_EN
   assign bus.q1_ready = entries[bus.q1_tag].busy && entries[bus.q1_tag].done;
   assign bus.q1_val   = entries[bus.q1_tag].val;
   assign bus.q2_ready = entries[bus.q2_tag].busy && entries[bus.q2_tag].done;
   assign bus.q2_val   = entries[bus.q2_tag].val;
`else
   logic unused_q_tags;
   assign unused_q_tags = ^{bus.q1_tag, bus.q2_tag};
   assign bus.q1_ready  = 1'b0;
   assign bus.q1_val    = '0;
   assign bus.q2_ready  = 1'b0;
   assign bus.q2_val    = '0;
`endif

   // Buffer state update.
   // Within one cycle the statements apply in this order: writeback, then
   // commit, then allocation. Commit and allocation never target the same
   // slot, because allocation is blocked whenever head==tail with live
   // entries (that is, when the buffer is full).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (bus.rdy) begin
         if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
               entries[i].busy <= 1'b0;
            end
         end else begin
            if (bus.wb_valid && entries[bus.wb_tag].busy) begin
               entries[bus.wb_tag].done <= 1'b1;
               entries[bus.wb_tag].val  <= bus.wb_val;
            end
            if (commit) begin
               entries[head].busy <= 1'b0;
               entries[head].done <= 1'b0;
               head               <= head + 1'b1;
            end
            if (accept) begin
               entries[tail] <= '{busy: 1'b1, done: 1'b0, has_rd: bus.alloc_has_rd,
                                  rd: bus.alloc_rd, val: '0};
               tail          <= tail + 1'b1;
            end
            count <= count + CNT_W'(accept) - CNT_W'(commit);
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Testbench for rob_commit_ctrl.
//
// The bench applies a table of per-cycle vectors, then hand-written
// sequences for the multi-cycle cases: full buffer, tag wrap-around,
// out-of-order writeback, flush, forwarding and asynchronous reset.
// The expected outputs of each vector are queued when the vector is driven,
// and popped when the outputs are sampled mid-cycle.
module tb_rob_commit_ctrl;

   typedef struct {
      int           id;
      logic         allocValid;
      logic         allocHasRd;
      logic [4:0]   allocRd;
      logic         wbValid;
      logic [3:0]   wbTag;
      logic [31:0]  wbVal;
      logic         flush;
      logic         rdy;
      logic         expReady;
      logic [3:0]   expTag;
      logic         expInFlag;
      logic [4:0]   expInA;
      logic [3:0]   expInRob;
      logic         expOutFlag;
      logic [4:0]   expOutA;
      logic [31:0]  expOutVal;
      logic [3:0]   expOutRob;
      logic         expClear;
   } vec_t;

   logic clk;
   logic rst;
   int   vecCount;
   int   missCount;
   int   nextId;
   vec_t expQ [$];
   vec_t vecTable [18];

   rob_commit_ctrl_if bus ();

   rob_commit_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds one vector: the inputs first, then the expected outputs.
   function automatic vec_t mk(int av, int ahr, int ard, int wv, int wt, logic [31:0] wval,
                               int fl, int rd, int eReady, int eTag, int eIn, int eInA,
                               int eInRob, int eOut, int eOutA, logic [31:0] eOutVal,
                               int eOutRob, int eClr);
      vec_t v;
      v.id         = nextId;
      nextId++;
      v.allocValid = av[0];
      v.allocHasRd = ahr[0];
      v.allocRd    = ard[4:0];
      v.wbValid    = wv[0];
      v.wbTag      = wt[3:0];
      v.wbVal      = wval;
      v.flush      = fl[0];
      v.rdy        = rd[0];
      v.expReady   = eReady[0];
      v.expTag     = eTag[3:0];
      v.expInFlag  = eIn[0];
      v.expInA     = eInA[4:0];
      v.expInRob   = eInRob[3:0];
      v.expOutFlag = eOut[0];
      v.expOutA    = eOutA[4:0];
      v.expOutVal  = eOutVal;
      v.expOutRob  = eOutRob[3:0];
      v.expClear   = eClr[0];
      return v;
   endfunction

   task automatic cmp(int id, string fld, logic [31:0] act, logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL vec%0d %s: got 0x%0h, expected 0x%0h", id, fld, act, exp);
      end
   endtask

   // Drives a vector on the falling edge and queues its expectations.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      bus.alloc_valid  = v.allocValid;
      bus.alloc_has_rd = v.allocHasRd;
      bus.alloc_rd     = v.allocRd;
      bus.wb_valid     = v.wbValid;
      bus.wb_tag       = v.wbTag;
      bus.wb_val       = v.wbVal;
      bus.flush        = v.flush;
      bus.rdy          = v.rdy;
      expQ.push_back(v);
   endtask

   // Samples the combinational outputs mid-cycle, well away from the edge.
   task automatic checkOutput();
      vec_t e;
      #2;
      if (expQ.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
         return;
      end
      e = expQ.pop_front();
      cmp(e.id, "alloc_ready", 32'(bus.alloc_ready), 32'(e.expReady));
      cmp(e.id, "alloc_tag",   32'(bus.alloc_tag),   32'(e.expTag));
      cmp(e.id, "rf_in_flag",  32'(bus.rf_in_flag),  32'(e.expInFlag));
      cmp(e.id, "rf_in_a",     32'(bus.rf_in_a),     32'(e.expInA));
      cmp(e.id, "rf_in_rob",   32'(bus.rf_in_rob),   32'(e.expInRob));
      cmp(e.id, "rf_out_flag", 32'(bus.rf_out_flag), 32'(e.expOutFlag));
      cmp(e.id, "rf_out_a",    32'(bus.rf_out_a),    32'(e.expOutA));
      cmp(e.id, "rf_out_val",  bus.rf_out_val,       e.expOutVal);
      cmp(e.id, "rf_out_rob",  32'(bus.rf_out_rob),  32'(e.expOutRob));
      cmp(e.id, "rf_clear",    32'(bus.rf_clear),    32'(e.expClear));
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   // Allocates n entries from startTag onward, with rd = rdBase + i.
   // No commits are expected while these entries are filled.
   task automatic fillEntries(int n, int startTag, int rdBase);
      for (int i = 0; i < n; i++) begin
         runVec(mk(1, 1, rdBase + i, 0, 0, 32'h0, 0, 1,
                   1, (startTag + i) % 16, 1, rdBase + i, (startTag + i) % 16,
                   0, 0, 32'h0, 0, 0));
      end
   endtask

   task automatic checkQuery(int t1, int t2, int r1, logic [31:0] v1, int r2, logic [31:0] v2);
      int id;
      id = nextId;
      nextId++;
      @(negedge clk);
      bus.alloc_valid = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.flush       = 1'b0;
      bus.rdy         = 1'b1;
      bus.q1_tag      = t1[3:0];
      bus.q2_tag      = t2[3:0];
      #2;
      cmp(id, "q1_ready", 32'(bus.q1_ready), 32'(r1));
      cmp(id, "q1_val",   bus.q1_val,        v1);
      cmp(id, "q2_ready", 32'(bus.q2_ready), 32'(r2));
      cmp(id, "q2_val",   bus.q2_val,        v2);
   endtask

   task automatic checkResetOutputs(int id);
      cmp(id, "rst.alloc_ready", 32'(bus.alloc_ready), 32'd0);
      cmp(id, "rst.alloc_tag",   32'(bus.alloc_tag),   32'd0);
      cmp(id, "rst.rf_in_flag",  32'(bus.rf_in_flag),  32'd0);
      cmp(id, "rst.rf_in_a",     32'(bus.rf_in_a),     32'd0);
      cmp(id, "rst.rf_out_flag", 32'(bus.rf_out_flag), 32'd0);
      cmp(id, "rst.rf_out_val",  bus.rf_out_val,       32'd0);
      cmp(id, "rst.rf_clear",    32'(bus.rf_clear),    32'd0);
      cmp(id, "rst.q1_ready",    32'(bus.q1_ready),    32'd0);
      cmp(id, "rst.q1_val",      bus.q1_val,           32'd0);
   endtask

   task automatic setIdle();
      bus.alloc_valid  = 1'b0;
      bus.alloc_has_rd = 1'b0;
      bus.alloc_rd     = '0;
      bus.wb_valid     = 1'b0;
      bus.wb_tag       = '0;
      bus.wb_val       = '0;
      bus.flush        = 1'b0;
      bus.rdy          = 1'b1;
   endtask

   // Main test sequence.
   initial begin
      int ord [16];
      int cur;
      int prv;
      logic [31:0] qVal;
      int          qRdy;

      vecCount  = 0;
      missCount = 0;
      nextId    = 0;
      bus.q1_tag = '0;
      bus.q2_tag = '0;

      // Reset is held while a request is being presented.
      rst              = 1'b0;
      bus.rdy          = 1'b1;
      bus.alloc_valid  = 1'b1;
      bus.alloc_has_rd = 1'b1;
      bus.alloc_rd     = 5'd5;
      bus.wb_valid     = 1'b0;
      bus.wb_tag       = '0;
      bus.wb_val       = '0;
      bus.flush        = 1'b0;
      #3;
      checkResetOutputs(1000);
      @(negedge clk);
      setIdle();
      rst = 1'b1;

      // Table: basic alloc/writeback/commit, rd=0 and no-rd entries,
      // rdy freeze, writeback to an idle slot, out-of-order writeback, flush.
      vecTable[0]  = mk(0,0,0, 0,0,32'h0,          0,1, 1,0, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[1]  = mk(1,1,5, 0,0,32'h0,          0,1, 1,0, 1,5,0, 0,0,32'h0,0,    0);
      vecTable[2]  = mk(0,0,0, 1,0,32'h1234,       0,1, 1,1, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[3]  = mk(0,0,0, 0,0,32'h0,          0,1, 1,1, 0,0,0, 1,5,32'h1234,0, 0);
      vecTable[4]  = mk(0,0,0, 0,0,32'h0,          0,1, 1,1, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[5]  = mk(1,1,0, 0,0,32'h0,          0,1, 1,1, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[6]  = mk(1,0,7, 0,0,32'h0,          0,1, 1,2, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[7]  = mk(1,1,9, 1,1,32'h5,          0,0, 0,3, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[8]  = mk(0,0,0, 0,0,32'h0,          1,0, 0,3, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[9]  = mk(0,0,0, 1,1,32'hAAAA5555,   0,1, 1,3, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[10] = mk(1,1,9, 1,2,32'h77,         0,1, 1,3, 1,9,3, 0,0,32'h0,0,    0);
      vecTable[11] = mk(0,0,0, 0,0,32'h0,          0,1, 1,4, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[12] = mk(0,0,0, 1,5,32'hDEAD,       0,1, 1,4, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[13] = mk(0,0,0, 1,3,32'h42,         0,1, 1,4, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[14] = mk(0,0,0, 0,0,32'h0,          0,1, 1,4, 0,0,0, 1,9,32'h42,3,   0);
      vecTable[15] = mk(0,0,0, 0,0,32'h0,          0,1, 1,4, 0,0,0, 0,0,32'h0,0,    0);
      vecTable[16] = mk(1,1,3, 0,0,32'h0,          1,1, 0,4, 0,0,0, 0,0,32'h0,0,    1);
      vecTable[17] = mk(0,0,0, 0,0,32'h0,          0,1, 1,0, 0,0,0, 0,0,32'h0,0,    0);
      for (int i = 0; i < 18; i++) begin
         runVec(vecTable[i]);
      end

      // Full buffer: a commit in the same cycle does not unblock allocation.
      fillEntries(16, 0, 1);
      runVec(mk(0,0,0,  0,0,32'h0,   0,1, 0,0, 0,0,0,  0,0,32'h0,0,   0));
      runVec(mk(0,0,0,  1,0,32'h100, 0,1, 0,0, 0,0,0,  0,0,32'h0,0,   0));
      runVec(mk(1,1,20, 0,0,32'h0,   0,1, 0,0, 0,0,0,  1,1,32'h100,0, 0));
      runVec(mk(0,0,0,  0,0,32'h0,   0,1, 1,0, 0,0,0,  0,0,32'h0,0,   0));
      runVec(mk(1,1,21, 0,0,32'h0,   0,1, 1,0, 1,21,0, 0,0,32'h0,0,   0));
      runVec(mk(0,0,0,  0,0,32'h0,   0,1, 0,1, 0,0,0,  0,0,32'h0,0,   0));
      runVec(mk(0,0,0,  0,0,32'h0,   1,1, 0,1, 0,0,0,  0,0,32'h0,0,   1));

      // Wrap-around: commit tags 0 and 1, reuse them, then drain in order.
      fillEntries(16, 0, 1);
      runVec(mk(0,0,0,  1,0,32'h1000, 0,1, 0,0, 0,0,0,  0,0,32'h0,0,    0));
      runVec(mk(0,0,0,  1,1,32'h1001, 0,1, 0,0, 0,0,0,  1,1,32'h1000,0, 0));
      runVec(mk(1,1,17, 0,0,32'h0,    0,1, 1,0, 1,17,0, 1,2,32'h1001,1, 0));
      runVec(mk(1,1,18, 0,0,32'h0,    0,1, 1,1, 1,18,1, 0,0,32'h0,0,    0));
      for (int k = 0; k < 16; k++) begin
         ord[k] = (k < 14) ? k + 2 : k - 14;
      end
      for (int k = 0; k <= 16; k++) begin
         cur = (k < 16) ? ord[k] : 0;
         prv = (k > 0) ? ord[k-1] : 0;
         runVec(mk(0, 0, 0, (k < 16) ? 1 : 0, cur, 32'h2000 + cur, 0, 1,
                   (k >= 2) ? 1 : 0, 2, 0, 0, 0,
                   (k >= 1) ? 1 : 0,
                   (k >= 1) ? ((prv >= 2) ? prv + 1 : prv + 17) : 0,
                   (k >= 1) ? 32'h2000 + prv : 32'h0,
                   (k >= 1) ? prv : 0, 0));
      end
      runVec(mk(0,0,0, 0,0,32'h0, 0,1, 1,2, 0,0,0, 0,0,32'h0,0, 0));
      runVec(mk(0,0,0, 0,0,32'h0, 1,1, 0,2, 0,0,0, 0,0,32'h0,0, 1));

      // Out-of-order writeback: tag 3 finishes before head tag 2.
      fillEntries(4, 0, 1);
      runVec(mk(0,0,0, 1,0,32'h10, 0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 1,1,32'h11, 0,1, 1,4, 0,0,0, 1,1,32'h10,0, 0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 1,2,32'h11,1, 0));
      runVec(mk(0,0,0, 1,3,32'h33, 0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 1,2,32'h22, 0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 1,3,32'h22,2, 0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 1,4,32'h33,3, 0));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,4, 0,0,0, 0,0,32'h0,0,  0));
      runVec(mk(0,0,0, 0,0,32'h0,  1,1, 0,4, 0,0,0, 0,0,32'h0,0,  1));

      // Flush with 7 busy entries and a commit-ready head.
      fillEntries(7, 0, 1);
      runVec(mk(0,0,0, 1,0,32'h55, 0,1, 1,7, 0,0,0, 0,0,32'h0,0, 0));
      runVec(mk(1,1,3, 0,0,32'h0,  1,1, 0,7, 0,0,0, 0,0,32'h0,0, 1));
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 1,0, 0,0,0, 0,0,32'h0,0, 0));
      fillEntries(16, 0, 1);
      runVec(mk(0,0,0, 0,0,32'h0,  0,1, 0,0, 0,0,0, 0,0,32'h0,0, 0));

      // Forwarding query against a done entry and a pending entry.
      runVec(mk(0,0,0, 1,4,32'hBEEF, 0,1, 0,0, 0,0,0, 0,0,32'h0,0, 0));
`ifdef ROB_BYPASS_EN
      qRdy = 1;
      qVal = 32'hBEEF;
`else
      qRdy = 0;
      qVal = 32'h0;
`endif
      checkQuery(4, 5, qRdy, qVal, 0, 32'h0);

      // Asynchronous reset asserted mid-cycle, away from any clock edge.
      @(negedge clk);
      bus.alloc_valid  = 1'b1;
      bus.alloc_has_rd = 1'b1;
      bus.alloc_rd     = 5'd5;
      bus.wb_valid     = 1'b0;
      bus.flush        = 1'b0;
      bus.rdy          = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checkResetOutputs(1001);
      bus.flush = 1'b1;
      #1;
      cmp(1002, "rst.rf_clear_flush", 32'(bus.rf_clear), 32'd0);
      @(negedge clk);
      setIdle();
      rst = 1'b1;
      runVec(mk(0,0,0, 0,0,32'h0, 0,1, 1,0, 0,0,0, 0,0,32'h0,0, 0));
      checkQuery(4, 5, 0, 32'h0, 0, 32'h0);

      if (expQ.size() != 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
